divider_4bit_seq: RTL and testbench
===================================

# divider_4bit_seq

Sequential unsigned integer divider: computes quotient and remainder of two WIDTH-bit operands by restoring (shift/trial-subtract) division, one quotient bit per clock. It is the inverse arithmetic companion to the team's combinational adder. It sits behind a start/busy/done handshake so that a controller or testbench can issue one division at a time.

## Interface
- WIDTH, 4, operand/result width in bits (legal range 2..16)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a division; sampled only in IDLE or DONE
- dividend  input  WIDTH  numerator, captured on the accepted start edge
- divisor  input  WIDTH  denominator, captured on the accepted start edge
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse; results valid and held from this cycle
- quotient  output  WIDTH  floor(dividend / divisor)
- remainder  output  WIDTH  dividend mod divisor
- div_by_zero  output  1  set with done when captured divisor was 0 (see Configuration)

## Operation
- One clock; reset is asynchronous and active-low.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> capture operands, clear working remainder, load iteration counter with WIDTH, go RUN. With the zero check enabled and divisor=0 -> go directly to DONE.
- RUN, each cycle: partial remainder (WIDTH+1 bits) = {rem, next dividend MSB}; trial = partial - divisor (zero-extended to WIDTH+1 bits); if trial non-negative, rem = trial and quotient bit = 1, else rem = partial and quotient bit = 0; shift the dividend left; decrement the counter. When the counter reaches 0, go DONE.
- DONE (lasts one cycle): done=1; quotient/remainder/div_by_zero registers loaded. If start=1 in this cycle, it is accepted exactly as in IDLE (back-to-back). Otherwise go IDLE.
- start in RUN is ignored; operand inputs are don't-care except on the accepted edge.
- Output registers change only on entry to DONE. They hold the previous result through IDLE and RUN.
- Divide by zero result: quotient = all ones, remainder = dividend, regardless of configuration.
- Reset (asserted at any time, including mid-RUN): state = IDLE; busy, done, div_by_zero, quotient, and remainder all 0; the in-flight operation is discarded and done is never asserted for it.

## Timing
- start sampled at edge k -> busy=1 after edge k through edge k+WIDTH; done=1 for the single cycle after edge k+WIDTH. Latency is WIDTH cycles (4 at default).
- Divide-by-zero with check enabled: done=1 in the cycle after edge k (latency 1); busy stays 0.
- Throughput with back-to-back starts: one result per WIDTH+1 cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- DIV_ZERO_CHECK_EN defined: divisor=0 short-circuits to DONE in 1 cycle with div_by_zero=1.
- DIV_ZERO_CHECK_EN undefined: divisor=0 runs the full WIDTH-cycle RUN sequence; the algorithm naturally yields quotient=all ones and remainder=dividend; div_by_zero is tied to 0.

## Structure
- Package divider_pkg: state enum typedef (IDLE, RUN, DONE) and the DIV_DEFAULT_WIDTH=4 constant.
- One sub-module: div_trial_sub, a combinational (WIDTH+1)-bit subtractor returning the difference and a borrow flag. Restore decision = !borrow.
- Counter width: $clog2(WIDTH+1).

## Test plan
- 13/3 (start at edge k) -> done in cycle after edge k+4; quotient=4, remainder=1, div_by_zero=0; busy high for exactly 4 cycles.
- 15/1 -> quotient=15, remainder=0; 0/5 -> quotient=0, remainder=0; 5/7 -> quotient=0, remainder=5.
- 7/0 with DIV_ZERO_CHECK_EN -> done 1 cycle after start; quotient=15, remainder=7, div_by_zero=1. Without the macro -> same values after 4 cycles, div_by_zero=0.
- start pulsed mid-RUN with 9/2 while 14/4 is running -> result 3 r 2 only; no extra done.
- start=1 during the DONE cycle of 14/4 with new operands 9/2 -> second done exactly 4 cycles later with 4 r 1.
- rst_n low during cycle 2 of RUN -> all outputs 0 immediately; no done; next start 6/3 -> 2 r 0.

Source files
------------

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding and default width for the sequential divider
package divider_pkg;

    localparam int DIV_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_trial_sub.sv
// rtl/div_trial_sub.sv - combinational trial subtractor; borrow set when i_a < i_b
module div_trial_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_diff,
    output logic         o_borrow
);

    assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

// File: rtl/divider_4bit_seq.sv
// rtl/divider_4bit_seq.sv - restoring divider, one quotient bit per clock
// Optional DIV_ZERO_CHECK_EN: divisor 0 finishes in one cycle and raises div_by_zero.
module divider_4bit_seq
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem_out;

    logic [WIDTH:0]   w_partial;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_dvd_next;
    logic             w_zero_skip;
    logic             w_unused;

    assign w_partial = {r_rem, r_dvd[WIDTH-1]};

    div_trial_sub #(.W(WIDTH + 1)) u_trial (
        .i_a      (w_partial),
        .i_b      ({1'b0, r_dvs}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // The working dividend register doubles as the quotient accumulator.
    assign w_rem_next = w_borrow ? w_partial : w_diff;
    assign w_dvd_next = {r_dvd[WIDTH-2:0], ~w_borrow};
    assign w_unused   = w_rem_next[WIDTH];

`ifdef DIV_ZERO_CHECK_EN
    assign w_zero_skip = (divisor == '0);
`else
    assign w_zero_skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_quot    <= '0;
            r_rem_out <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    r_rem <= w_rem_next[WIDTH-1:0];
                    r_dvd <= w_dvd_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_quot    <= w_dvd_next;
                        r_rem_out <= w_rem_next[WIDTH-1:0];
                        r_dbz     <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    r_done <= 1'b0;
                    if (start) begin
                        r_dvd <= dividend;
                        r_dvs <= divisor;
                        r_rem <= '0;
                        r_cnt <= CW'(WIDTH);
                        if (w_zero_skip) begin
                            r_state   <= DONE;
                            r_done    <= 1'b1;
                            r_quot    <= '1;
                            r_rem_out <= dividend;
                            r_dbz     <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem_out;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_4bit_seq.sv
// tb/tb_divider_4bit_seq.sv - scoreboard bench for divider_4bit_seq with random and directed cases
module tb_divider_4bit_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    divider_4bit_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int r;
        int dbz;
        int done_cyc;
        int busy_cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   busy_run = 0;

    always @(posedge clk) cyc++;

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic exp_t model(int a, int b, int start_edge);
        exp_t e;
        int   lat;
        if (b == 0) begin
            e.q = (1 << W) - 1;
            e.r = a;
`ifdef DIV_ZERO_CHECK_EN
            e.dbz = 1;
            lat = 1;
            e.busy_cycles = 0;
`else
            e.dbz = 0;
            lat = W;
            e.busy_cycles = W;
`endif
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dbz = 0;
            lat = W;
            e.busy_cycles = W;
        end
        e.done_cyc = start_edge + lat;
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT reports a result.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quotient", int'(quotient), e.q);
                    check("remainder", int'(remainder), e.r);
                    check("div_by_zero", int'(div_by_zero), e.dbz);
                    check("done_cycle", cyc, e.done_cyc);
                    check("busy_cycles", busy_run, e.busy_cycles);
                end
                busy_run = 0;
            end
        end
    end

    task automatic issue(input int a, input int b, input bit expect_result);
        start = 1'b1;
        dividend = W'(a);
        divisor = W'(b);
        if (expect_result) sb.push_back(model(a, b, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        dividend = W'($urandom);
        divisor = W'($urandom);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic do_div(input int a, input int b);
        exp_t e;
        e = model(a, b, 0);
        issue(a, b, 1'b1);
        wait_done();
        repeat (2) @(negedge clk);
        check("hold_quotient", int'(quotient), e.q);
        check("hold_remainder", int'(remainder), e.r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_remainder", int'(remainder), 0);
        check("reset_dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_div(13, 3);
        do_div(15, 1);
        do_div(0, 5);
        do_div(5, 7);
        do_div(7, 0);
        do_div(15, 15);

        // start during RUN must be ignored
        issue(14, 4, 1'b1);
        @(negedge clk);
        start = 1'b1;
        dividend = 4'd9;
        divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (10) @(negedge clk);

        // back-to-back start in the DONE cycle
        issue(14, 4, 1'b1);
        wait_done();
        issue(9, 2, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);

        // reset in the second RUN cycle discards the operation
        issue(14, 4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", int'(busy), 0);
        check("midrun_rst_done", int'(done), 0);
        check("midrun_rst_quotient", int'(quotient), 0);
        check("midrun_rst_remainder", int'(remainder), 0);
        check("midrun_rst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        do_div(6, 3);

        // random operands; zero idle gap exercises back-to-back acceptance
        for (int i = 0; i < 40; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 15));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 15));
            issue(a, b, 1'b1);
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
